// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage data-memory interface. Turns the EX/MEM load/store flags and the
// ALU effective address into a single req/ack bus transaction with byte
// enables. It holds the pipeline in mem_stall until the bus answers or the
// timeout expires, then presents the extended load result (or a bus error)
// for exactly one cycle (DONE) so the instruction advances once.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   valid_M, flush_M           MEM-stage instruction valid / squash
//   MemRead_M, MemWrite_M      load / store instruction
//   LOAD_*_M, STORE_*_M        one-hot access size (none set => word)
//   ALUOut_M                   effective byte address
//   WriteData_M                right-justified store data
//   dmem_req/we/addr/be/wdata  bus request side, stable while in REQ
//   dmem_rdata, dmem_ack       bus response (ack is a one-cycle pulse)
//   ReadData_M                 extended load result, valid in DONE
//   mem_stall                  freeze IF..MEM
//   AddrErr_M                  misaligned access (combinational, no bus cycle)
//   BusErr_M                   timeout flag, valid in DONE
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_M,
    input  logic        flush_M,
    input  logic        MemRead_M,
    input  logic        MemWrite_M,
    input  logic        LOAD_BYTE_M,
    input  logic        LOAD_HW_M,
    input  logic        LOAD_WORD_M,
    input  logic        LOAD_BYTE_UNSIGNED_M,
    input  logic        LOAD_HW_UNSIGNED_M,
    input  logic        STORE_BYTE_M,
    input  logic        STORE_HW_M,
    input  logic        STORE_WORD_M,
    input  logic [31:0] ALUOut_M,
    input  logic [31:0] WriteData_M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] ReadData_M,
    output logic        mem_stall,
    output logic        AddrErr_M,
    output logic        BusErr_M
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    // The counter reaches TIMEOUT_CYCLES at the end of the last allowed REQ
    // cycle, so the give-up decision is taken while it still reads one less.
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] tmo_cnt;

    // Load shape captured at request time; the EX/MEM inputs may change
    // (e.g. flush) before the ack arrives.
    logic       ld_byte;
    logic       ld_half;
    logic       ld_signed;
    logic [1:0] ld_off;

    logic        active;
    logic        access;
    logic        sel_byte;
    logic        sel_half;
    logic        sel_word;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] ext_data;

    // Size decode: store flags for stores, load flags otherwise.
    // With no size flag asserted the access is treated as a word.
    always_comb begin
        active = valid_M & ~flush_M;
        if (MemWrite_M) begin
            sel_byte = STORE_BYTE_M;
            sel_half = STORE_HW_M;
            sel_word = STORE_WORD_M | ~(STORE_BYTE_M | STORE_HW_M);
        end else begin
            sel_byte = LOAD_BYTE_M | LOAD_BYTE_UNSIGNED_M;
            sel_half = LOAD_HW_M | LOAD_HW_UNSIGNED_M;
            sel_word = LOAD_WORD_M | ~(sel_byte | sel_half);
        end

        // Only memory instructions can be misaligned; ALU results that
        // happen to be odd must not raise an address error.
        AddrErr_M = active & (MemRead_M | MemWrite_M) &
                    ((sel_half & ALUOut_M[0]) | (sel_word & (|ALUOut_M[1:0])));
        access    = active & (MemRead_M | MemWrite_M) & ~AddrErr_M;

        if (sel_byte) begin
            be_next    = 4'b0001 << ALUOut_M[1:0];
            wdata_next = {4{WriteData_M[7:0]}};
        end else if (sel_half) begin
            be_next    = ALUOut_M[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{WriteData_M[15:0]}};
        end else begin
            be_next    = 4'b1111;
            wdata_next = WriteData_M;
        end
    end

    // Lane extraction and extension of the returning read data.
    always_comb begin
        lane_byte = dmem_rdata[{ld_off, 3'b000} +: 8];
        lane_half = ld_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        if (ld_byte) begin
            ext_data = {{24{ld_signed & lane_byte[7]}}, lane_byte};
        end else if (ld_half) begin
            ext_data = {{16{ld_signed & lane_half[15]}}, lane_half};
        end else begin
            ext_data = dmem_rdata;
        end
    end

    // DONE deliberately drops the stall so the instruction leaves MEM once.
    assign mem_stall = ((state == IDLE) & access) | (state == REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= '0;
            dmem_wdata <= '0;
            ReadData_M <= '0;
            BusErr_M   <= 1'b0;
            tmo_cnt    <= '0;
            ld_byte    <= 1'b0;
            ld_half    <= 1'b0;
            ld_signed  <= 1'b0;
            ld_off     <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        state      <= REQ;
                        dmem_req   <= 1'b1;
                        dmem_we    <= MemWrite_M;
                        dmem_addr  <= {ALUOut_M[31:2], 2'b00};
                        dmem_be    <= be_next;
                        dmem_wdata <= wdata_next;
                        tmo_cnt    <= '0;
                        ld_byte    <= sel_byte;
                        ld_half    <= sel_half;
                        ld_signed  <= ~MemWrite_M & (LOAD_BYTE_M | LOAD_HW_M);
                        ld_off     <= ALUOut_M[1:0];
                    end
                end
                REQ: begin
                    // An ack on the final allowed cycle still completes normally.
                    if (dmem_ack) begin
                        state      <= DONE;
                        dmem_req   <= 1'b0;
                        ReadData_M <= ext_data;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state      <= DONE;
                        dmem_req   <= 1'b0;
                        ReadData_M <= '0;
                        BusErr_M   <= 1'b1;
                        tmo_cnt    <= tmo_cnt + CW'(1);
                    end else begin
                        tmo_cnt    <= tmo_cnt + CW'(1);
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    BusErr_M <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_M, flush_M, MemRead_M, MemWrite_M;
    logic        LOAD_BYTE_M, LOAD_HW_M, LOAD_WORD_M, LOAD_BYTE_UNSIGNED_M, LOAD_HW_UNSIGNED_M;
    logic        STORE_BYTE_M, STORE_HW_M, STORE_WORD_M;
    logic [31:0] ALUOut_M, WriteData_M;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] ReadData_M;
    logic        mem_stall, AddrErr_M, BusErr_M;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .valid_M              (valid_M),
        .flush_M              (flush_M),
        .MemRead_M            (MemRead_M),
        .MemWrite_M           (MemWrite_M),
        .LOAD_BYTE_M          (LOAD_BYTE_M),
        .LOAD_HW_M            (LOAD_HW_M),
        .LOAD_WORD_M          (LOAD_WORD_M),
        .LOAD_BYTE_UNSIGNED_M (LOAD_BYTE_UNSIGNED_M),
        .LOAD_HW_UNSIGNED_M   (LOAD_HW_UNSIGNED_M),
        .STORE_BYTE_M         (STORE_BYTE_M),
        .STORE_HW_M           (STORE_HW_M),
        .STORE_WORD_M         (STORE_WORD_M),
        .ALUOut_M             (ALUOut_M),
        .WriteData_M          (WriteData_M),
        .dmem_req             (dmem_req),
        .dmem_we              (dmem_we),
        .dmem_addr            (dmem_addr),
        .dmem_be              (dmem_be),
        .dmem_wdata           (dmem_wdata),
        .dmem_rdata           (dmem_rdata),
        .dmem_ack             (dmem_ack),
        .ReadData_M           (ReadData_M),
        .mem_stall            (mem_stall),
        .AddrErr_M            (AddrErr_M),
        .BusErr_M             (BusErr_M)
    );

    // size flag vector order: {LB, LH, LW, LBU, LHU, SB, SH, SW}
    localparam logic [7:0] F_NONE = 8'h00;
    localparam logic [7:0] F_LB   = 8'h80;
    localparam logic [7:0] F_LH   = 8'h40;
    localparam logic [7:0] F_LW   = 8'h20;
    localparam logic [7:0] F_LBU  = 8'h10;
    localparam logic [7:0] F_LHU  = 8'h08;
    localparam logic [7:0] F_SB   = 8'h04;
    localparam logic [7:0] F_SH   = 8'h02;
    localparam logic [7:0] F_SW   = 8'h01;

    typedef struct packed {
        logic [31:0] rd;
        logic        berr;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic clear_inputs();
        valid_M = 1'b0; flush_M = 1'b0; MemRead_M = 1'b0; MemWrite_M = 1'b0;
        {LOAD_BYTE_M, LOAD_HW_M, LOAD_WORD_M, LOAD_BYTE_UNSIGNED_M, LOAD_HW_UNSIGNED_M,
         STORE_BYTE_M, STORE_HW_M, STORE_WORD_M} = 8'h00;
        ALUOut_M = 32'h0; WriteData_M = 32'h0;
    endtask

    task automatic drive_instr(input logic rd, input logic wr, input logic [7:0] fl,
                               input logic [31:0] addr, input logic [31:0] wd);
        valid_M = 1'b1; flush_M = 1'b0; MemRead_M = rd; MemWrite_M = wr;
        {LOAD_BYTE_M, LOAD_HW_M, LOAD_WORD_M, LOAD_BYTE_UNSIGNED_M, LOAD_HW_UNSIGNED_M,
         STORE_BYTE_M, STORE_HW_M, STORE_WORD_M} = fl;
        ALUOut_M = addr; WriteData_M = wd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear_inputs(); dmem_ack = 1'b0; dmem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || BusErr_M !== 1'b0 || mem_stall !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: req=%b we=%b buserr=%b stall=%b, required all 0",
                     dmem_req, dmem_we, BusErr_M, mem_stall);
        end
        n_cmp++;
        if (dmem_addr !== 32'h0 || dmem_be !== 4'h0 || dmem_wdata !== 32'h0 || ReadData_M !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data: addr=%h be=%b wdata=%h rdata=%h, required all 0",
                     dmem_addr, dmem_be, dmem_wdata, ReadData_M);
        end
        $display("txn reset: outputs checked");
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ack_at: REQ cycle (1-based) in which the bus acks, 0 = never.
    task automatic run_txn(input string name, input logic rd, input logic wr, input logic [7:0] fl,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                           input int ack_at, input logic flush_mid,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd,
                           input logic [31:0] exp_rd, input logic exp_berr, input int exp_req);
        exp_t e;
        int   req_n;
        int   stall_n;
        bit   done;
        @(negedge clk);
        drive_instr(rd, wr, fl, addr, wd);
        dmem_ack = 1'b0;
        #1;
        n_cmp++;
        if (mem_stall !== 1'b1 || AddrErr_M !== 1'b0) begin
            n_err++;
            $display("FAIL %s_start: stall=%b adderr=%b, required 1/0", name, mem_stall, AddrErr_M);
        end
        e.rd = exp_rd; e.berr = exp_berr;
        sb_q.push_back(e);
        req_n = 0; stall_n = 1; done = 0;
        for (int c = 0; c < 32 && !done; c++) begin
            @(negedge clk);
            if (dmem_req === 1'b1) begin
                req_n++;
                if (mem_stall === 1'b1) stall_n++;
                n_cmp++;
                if (dmem_we !== wr || dmem_addr !== {addr[31:2], 2'b00} || dmem_be !== exp_be ||
                    (wr && dmem_wdata !== exp_wd)) begin
                    n_err++;
                    $display("FAIL %s_bus: we=%b addr=%h be=%b wdata=%h, required we=%b addr=%h be=%b wdata=%h",
                             name, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                             wr, {addr[31:2], 2'b00}, exp_be, exp_wd);
                end
                if (flush_mid) flush_M = 1'b1;
                if (req_n == ack_at) begin
                    dmem_ack = 1'b1; dmem_rdata = rdata;
                end else begin
                    dmem_ack = 1'b0; dmem_rdata = $urandom;
                end
            end else begin
                done = 1;
                dmem_ack = 1'b0;
                e = sb_q.pop_front();
                n_cmp++;
                if (ReadData_M !== e.rd || BusErr_M !== e.berr) begin
                    n_err++;
                    $display("FAIL %s_result: rdata=%h buserr=%b, required rdata=%h buserr=%b",
                             name, ReadData_M, BusErr_M, e.rd, e.berr);
                end
                n_cmp++;
                if (mem_stall !== 1'b0 || req_n != exp_req || stall_n != exp_req + 1) begin
                    n_err++;
                    $display("FAIL %s_timing: done_stall=%b req_cycles=%0d stall_cycles=%0d, required 0/%0d/%0d",
                             name, mem_stall, req_n, stall_n, exp_req, exp_req + 1);
                end
                clear_inputs();
            end
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL %s_hang: DONE not reached, required completion within 32 cycles", name);
            clear_inputs();
        end
        @(negedge clk);
        n_cmp++;
        if (BusErr_M !== 1'b0 || dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
            n_err++;
            $display("FAIL %s_idle: buserr=%b req=%b stall=%b, required 0/0/0", name, BusErr_M, dmem_req, mem_stall);
        end
        $display("txn %s: addr=%h req_cycles=%0d rdata=%h buserr=%b", name, addr, req_n, e.rd, e.berr);
    endtask

    task automatic test_loads_stores();
        run_txn("lb",   1, 0, F_LB,   32'h103, 32'h0,        32'h80AA_BBCC, 2, 0, 4'b1000, 32'h0, 32'hFFFF_FF80, 0, 2);
        run_txn("lhu",  1, 0, F_LHU,  32'h102, 32'h0,        32'h9234_5678, 1, 0, 4'b1100, 32'h0, 32'h0000_9234, 0, 1);
        run_txn("sb",   0, 1, F_SB,   32'h101, 32'h0000_00A5, 32'h0,        1, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0, 0, 1);
        run_txn("lh",   1, 0, F_LH,   32'h100, 32'h0,        32'h1234_8001, 1, 0, 4'b0011, 32'h0, 32'hFFFF_8001, 0, 1);
        run_txn("lw",   1, 0, F_LW,   32'h104, 32'h0,        32'hDEAD_BEEF, 3, 0, 4'b1111, 32'h0, 32'hDEAD_BEEF, 0, 3);
        run_txn("sh",   0, 1, F_SH,   32'h106, 32'h1234_ABCD, 32'h0,        1, 0, 4'b1100, 32'hABCD_ABCD, 32'h0, 0, 1);
        run_txn("lbu",  1, 0, F_LBU,  32'h102, 32'h0,        32'h11F2_2233, 1, 0, 4'b0100, 32'h0, 32'h0000_00F2, 0, 1);
        run_txn("sw",   0, 1, F_SW,   32'h10C, 32'hCAFE_F00D, 32'h0,        2, 0, 4'b1111, 32'hCAFE_F00D, 32'h0, 0, 2);
        run_txn("noflg",1, 0, F_NONE, 32'h110, 32'h0,        32'h7654_3210, 1, 0, 4'b1111, 32'h0, 32'h7654_3210, 0, 1);
    endtask

    task automatic test_timeout();
        run_txn("tmo",     1, 0, F_LW, 32'h108, 32'h0, 32'h1111_2222, 0, 0, 4'b1111, 32'h0, 32'h0, 1, 4);
        run_txn("ack_tmo", 1, 0, F_LW, 32'h10C, 32'h0, 32'h3333_4444, 4, 0, 4'b1111, 32'h0, 32'h3333_4444, 0, 4);
    endtask

    task automatic test_flush_in_req();
        run_txn("flush", 1, 0, F_LB, 32'h200, 32'h0, 32'h0000_007F, 2, 1, 4'b0001, 32'h0, 32'h0000_007F, 0, 2);
    endtask

    task automatic test_addr_err();
        @(negedge clk);
        drive_instr(1, 0, F_LW, 32'h102, 32'h0);
        #1;
        n_cmp++;
        if (AddrErr_M !== 1'b1 || mem_stall !== 1'b0) begin
            n_err++;
            $display("FAIL addrerr_flag: adderr=%b stall=%b, required 1/0", AddrErr_M, mem_stall);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
                n_err++;
                $display("FAIL addrerr_noreq: req=%b stall=%b, required 0/0", dmem_req, mem_stall);
            end
        end
        drive_instr(1, 0, F_LH, 32'h105, 32'h0);
        #1;
        n_cmp++;
        if (AddrErr_M !== 1'b1) begin
            n_err++;
            $display("FAIL addrerr_half: adderr=%b, required 1", AddrErr_M);
        end
        clear_inputs();
        $display("txn addrerr: lw 0x102 and lh 0x105 rejected");
    endtask

    // LW then SW with ack stuck high: ack outside REQ must not matter.
    task automatic test_back_to_back();
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_F00D;
        drive_instr(1, 0, F_LW, 32'h300, 32'h0);
        @(negedge clk);
        n_cmp++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h300) begin
            n_err++;
            $display("FAIL b2b_lw_req: req=%b we=%b addr=%h, required 1/0/00000300", dmem_req, dmem_we, dmem_addr);
        end
        @(negedge clk);
        n_cmp++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || ReadData_M !== 32'h0BAD_F00D) begin
            n_err++;
            $display("FAIL b2b_lw_done: req=%b stall=%b rdata=%h, required 0/0/0badf00d", dmem_req, mem_stall, ReadData_M);
        end
        drive_instr(0, 1, F_SW, 32'h304, 32'h5566_7788);
        @(negedge clk);
        n_cmp++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_idle: req=%b stall=%b, required 0/1", dmem_req, mem_stall);
        end
        @(negedge clk);
        n_cmp++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h304 || dmem_wdata !== 32'h5566_7788) begin
            n_err++;
            $display("FAIL b2b_sw_req: req=%b we=%b addr=%h wdata=%h, required 1/1/00000304/55667788",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata);
        end
        @(negedge clk);
        n_cmp++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_sw_done: req=%b stall=%b, required 0/0", dmem_req, mem_stall);
        end
        clear_inputs();
        dmem_ack = 1'b0;
        @(negedge clk);
        $display("txn back_to_back: lw 0x300 then sw 0x304");
    endtask

    task automatic test_reset_mid_req();
        @(negedge clk);
        drive_instr(1, 0, F_LW, 32'h400, 32'h0);
        @(negedge clk);
        n_cmp++;
        if (dmem_req !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_pre: req=%b, required 1", dmem_req);
        end
        clear_inputs();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dmem_req !== 1'b0 || mem_stall !== 1'b0 || dmem_be !== 4'h0) begin
            n_err++;
            $display("FAIL rst_mid: req=%b stall=%b be=%b, required 0/0/0000", dmem_req, mem_stall, dmem_be);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("txn reset_mid_req: request dropped");
    endtask

    initial begin
        test_reset();
        test_loads_stores();
        test_timeout();
        test_flush_in_req();
        test_addr_err();
        test_back_to_back();
        test_reset_mid_req();
        run_txn("post_rst", 1, 0, F_LHU, 32'h500, 32'h0, 32'hAAAA_FFFE, 1, 0, 4'b0011, 32'h0, 32'h0000_FFFE, 0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
